// File: rtl/ex_stage_if.sv
// Bundle between the ID/EX register, the MEM/WB writeback bus and the EX/MEM register
// as seen by the execute stage. The master drives the ID/EX and writeback side.
interface ex_stage_if;
    logic        reg_dst;
    logic        alu_src;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        mem_to_reg;
    logic [2:0]  alu_op;
    logic [31:0] read_data_1;
    logic [31:0] read_data_2;
    logic [31:0] ins_15_0;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;

    logic        mem_wb_reg_write;
    logic [4:0]  mem_wb_rd;
    logic [31:0] mem_wb_data;

    logic        ex_mem_reg_write;
    logic        ex_mem_mem_to_reg;
    logic        ex_mem_mem_read;
    logic        ex_mem_mem_write;
    logic [31:0] ex_mem_alu_result;
    logic [31:0] ex_mem_write_data;
    logic [4:0]  ex_mem_write_reg;
    logic        ex_mem_zero;

    modport master (
        output reg_dst, alu_src, mem_read, mem_write, reg_write, mem_to_reg,
        output alu_op, read_data_1, read_data_2, ins_15_0, rs, rt, rd,
        output mem_wb_reg_write, mem_wb_rd, mem_wb_data,
        input  ex_mem_reg_write, ex_mem_mem_to_reg, ex_mem_mem_read, ex_mem_mem_write,
        input  ex_mem_alu_result, ex_mem_write_data, ex_mem_write_reg, ex_mem_zero
    );

    modport slave (
        input  reg_dst, alu_src, mem_read, mem_write, reg_write, mem_to_reg,
        input  alu_op, read_data_1, read_data_2, ins_15_0, rs, rt, rd,
        input  mem_wb_reg_write, mem_wb_rd, mem_wb_data,
        output ex_mem_reg_write, ex_mem_mem_to_reg, ex_mem_mem_read, ex_mem_mem_write,
        output ex_mem_alu_result, ex_mem_write_data, ex_mem_write_reg, ex_mem_zero
    );
endinterface

// File: rtl/ex_stage.sv
// MIPS execute stage: operand forwarding from EX/MEM and MEM/WB, the ALU, destination
// select, and the EX/MEM pipeline register. Never stalls; reset is async active-low.
module ex_stage (
    input  logic       clk,
    input  logic       reset,
    ex_stage_if.slave  bus
);

    logic        r_regWrite;
    logic        r_memToReg;
    logic        r_memRead;
    logic        r_memWrite;
    logic [31:0] r_aluResult;
    logic [31:0] r_writeData;
    logic [4:0]  r_writeReg;
    logic        r_zero;

    logic        w_exMemFwdOk;
    logic        w_memWbFwdOk;
    logic [31:0] w_fwdA;
    logic [31:0] w_fwdB;
    logic        w_zeroExtImm;
    logic [31:0] w_imm;
    logic [31:0] w_opA;
    logic [31:0] w_opB;
    logic [4:0]  w_shamt;
    logic [5:0]  w_funct;
    logic        w_slt;
    logic [31:0] w_aluResult;
    logic [4:0]  w_writeReg;

    // A load still in EX/MEM only has its address, so it must not be forwarded from there.
    assign w_exMemFwdOk = r_regWrite && !r_memToReg && (r_writeReg != 5'd0);
    assign w_memWbFwdOk = bus.mem_wb_reg_write && (bus.mem_wb_rd != 5'd0);

    always_comb begin
        w_fwdA = bus.read_data_1;
        if (w_exMemFwdOk && (r_writeReg == bus.rs))
            w_fwdA = r_aluResult;
        else if (w_memWbFwdOk && (bus.mem_wb_rd == bus.rs))
            w_fwdA = bus.mem_wb_data;
    end

    always_comb begin
        w_fwdB = bus.read_data_2;
        if (w_exMemFwdOk && (r_writeReg == bus.rt))
            w_fwdB = r_aluResult;
        else if (w_memWbFwdOk && (bus.mem_wb_rd == bus.rt))
            w_fwdB = bus.mem_wb_data;
    end

    // Logical immediates (andi/ori) use the raw 16 bits rather than the sign-extended word.
    assign w_zeroExtImm = (bus.alu_op == 3'b011) || (bus.alu_op == 3'b100);
    assign w_imm        = w_zeroExtImm ? {16'b0, bus.ins_15_0[15:0]} : bus.ins_15_0;
    assign w_opA        = w_fwdA;
    assign w_opB        = bus.alu_src ? w_imm : w_fwdB;
    assign w_shamt      = bus.ins_15_0[10:6];
    assign w_funct      = bus.ins_15_0[5:0];
    assign w_slt        = $signed(w_opA) < $signed(w_opB);

    always_comb begin
        w_aluResult = 32'd0;
        case (bus.alu_op)
            3'b000: w_aluResult = w_opA + w_opB;
            3'b001: w_aluResult = w_opA - w_opB;
            3'b010: begin
                case (w_funct)
                    6'h20:   w_aluResult = w_opA + w_opB;
                    6'h22:   w_aluResult = w_opA - w_opB;
                    6'h24:   w_aluResult = w_opA & w_opB;
                    6'h25:   w_aluResult = w_opA | w_opB;
                    6'h26:   w_aluResult = w_opA ^ w_opB;
                    6'h27:   w_aluResult = ~(w_opA | w_opB);
                    6'h2A:   w_aluResult = {31'd0, w_slt};
                    6'h00:   w_aluResult = w_opB << w_shamt;
                    6'h02:   w_aluResult = w_opB >> w_shamt;
                    6'h03:   w_aluResult = $signed(w_opB) >>> w_shamt;
                    default: w_aluResult = 32'd0;
                endcase
            end
            3'b011: w_aluResult = w_opA & w_opB;
            3'b100: w_aluResult = w_opA | w_opB;
            3'b101: w_aluResult = {31'd0, w_slt};
            3'b110: w_aluResult = {w_opB[15:0], 16'b0};
            3'b111: w_aluResult = w_opA ^ w_opB;
            default: w_aluResult = 32'd0;
        endcase
    end

    assign w_writeReg = bus.reg_dst ? bus.rd : bus.rt;

    // EX/MEM register: captures every cycle; bubbles arrive as zero control from ID/EX.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_regWrite  <= 1'b0;
            r_memToReg  <= 1'b0;
            r_memRead   <= 1'b0;
            r_memWrite  <= 1'b0;
            r_aluResult <= 32'd0;
            r_writeData <= 32'd0;
            r_writeReg  <= 5'd0;
            r_zero      <= 1'b0;
        end else begin
            r_regWrite  <= bus.reg_write;
            r_memToReg  <= bus.mem_to_reg;
            r_memRead   <= bus.mem_read;
            r_memWrite  <= bus.mem_write;
            r_aluResult <= w_aluResult;
            r_writeData <= w_fwdB;
            r_writeReg  <= w_writeReg;
            r_zero      <= (w_aluResult == 32'd0);
        end
    end

    assign bus.ex_mem_reg_write  = r_regWrite;
    assign bus.ex_mem_mem_to_reg = r_memToReg;
    assign bus.ex_mem_mem_read   = r_memRead;
    assign bus.ex_mem_mem_write  = r_memWrite;
    assign bus.ex_mem_alu_result = r_aluResult;
    assign bus.ex_mem_write_data = r_writeData;
    assign bus.ex_mem_write_reg  = r_writeReg;
    assign bus.ex_mem_zero       = r_zero;

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed pipeline scenarios plus random instruction streams
// compared against an instruction-level model of the execute stage.
module tb_ex_stage;

    logic clk;
    logic reset;

    ex_stage_if bus ();

    ex_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int numChecks = 0;
    int numFails  = 0;

    // Model of what the EX/MEM register should hold after each edge.
    logic        mRegWrite, mMemToReg, mMemRead, mMemWrite, mZero;
    logic [31:0] mResult, mWriteData;
    logic [4:0]  mWriteReg;

    logic [5:0] functList [10] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26,
                                   6'h27, 6'h2A, 6'h00, 6'h02, 6'h03};

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        numChecks++;
        if (observed !== expected) begin
            numFails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    function automatic logic [31:0] refOperand(input logic [4:0] addr, input logic [31:0] idVal);
        if (mRegWrite && !mMemToReg && mWriteReg != 0 && mWriteReg == addr)
            return mResult;
        if (bus.mem_wb_reg_write && bus.mem_wb_rd != 0 && bus.mem_wb_rd == addr)
            return bus.mem_wb_data;
        return idVal;
    endfunction

    function automatic logic [31:0] refAlu(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [5:0] funct,
                                           input logic [4:0] sh);
        longint sa, sb, ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        case (op)
            3'd0: return 32'(ua + ub);
            3'd1: return 32'(ua - ub);
            3'd2: begin
                case (funct)
                    6'h20: return 32'(ua + ub);
                    6'h22: return 32'(ua - ub);
                    6'h24: return a & b;
                    6'h25: return a | b;
                    6'h26: return a ^ b;
                    6'h27: return ~(a | b);
                    6'h2A: return (sa < sb) ? 32'd1 : 32'd0;
                    6'h00: return 32'(ub * (longint'(1) << sh));
                    6'h02: return 32'(ub / (longint'(1) << sh));
                    6'h03: return 32'(sb >>> sh);
                    default: return 32'd0;
                endcase
            end
            3'd3: return a & b;
            3'd4: return a | b;
            3'd5: return (sa < sb) ? 32'd1 : 32'd0;
            3'd6: return 32'(ub * 65536);
            default: return a ^ b;
        endcase
    endfunction

    task automatic resetModel();
        mRegWrite  = 0; mMemToReg = 0; mMemRead = 0; mMemWrite = 0; mZero = 0;
        mResult    = 0; mWriteData = 0; mWriteReg = 0;
    endtask

    task automatic stepModel();
        logic [31:0] a, b, bRt, imm, res;
        logic [4:0]  wr;
        a   = refOperand(bus.rs, bus.read_data_1);
        bRt = refOperand(bus.rt, bus.read_data_2);
        if (bus.alu_op == 3'd3 || bus.alu_op == 3'd4)
            imm = bus.ins_15_0 & 32'h0000FFFF;
        else
            imm = bus.ins_15_0;
        b   = bus.alu_src ? imm : bRt;
        res = refAlu(bus.alu_op, a, b, bus.ins_15_0[5:0], bus.ins_15_0[10:6]);
        wr  = bus.reg_dst ? bus.rd : bus.rt;
        mRegWrite  = bus.reg_write;
        mMemToReg  = bus.mem_to_reg;
        mMemRead   = bus.mem_read;
        mMemWrite  = bus.mem_write;
        mResult    = res;
        mWriteData = bRt;
        mWriteReg  = wr;
        mZero      = (res == 0);
    endtask

    task automatic compareAll();
        checkOutput("regWrite",  {31'b0, bus.ex_mem_reg_write},  {31'b0, mRegWrite});
        checkOutput("memToReg",  {31'b0, bus.ex_mem_mem_to_reg}, {31'b0, mMemToReg});
        checkOutput("memRead",   {31'b0, bus.ex_mem_mem_read},   {31'b0, mMemRead});
        checkOutput("memWrite",  {31'b0, bus.ex_mem_mem_write},  {31'b0, mMemWrite});
        checkOutput("aluResult", bus.ex_mem_alu_result,          mResult);
        checkOutput("writeData", bus.ex_mem_write_data,          mWriteData);
        checkOutput("writeReg",  {27'b0, bus.ex_mem_write_reg},  {27'b0, mWriteReg});
        checkOutput("zero",      {31'b0, bus.ex_mem_zero},       {31'b0, mZero});
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".ctrl"}, {28'b0, bus.ex_mem_reg_write, bus.ex_mem_mem_to_reg,
                                     bus.ex_mem_mem_read, bus.ex_mem_mem_write}, 32'd0);
        checkOutput({tag, ".result"}, bus.ex_mem_alu_result, 32'd0);
        checkOutput({tag, ".wdata"},  bus.ex_mem_write_data, 32'd0);
        checkOutput({tag, ".wreg"},   {27'b0, bus.ex_mem_write_reg}, 32'd0);
        checkOutput({tag, ".zero"},   {31'b0, bus.ex_mem_zero}, 32'd0);
    endtask

    task automatic setIdEx(input logic regDst, input logic aluSrc, input logic memRead,
                           input logic memWrite, input logic regWrite, input logic memToReg,
                           input logic [2:0] aluOp, input logic [31:0] rd1,
                           input logic [31:0] rd2, input logic [31:0] imm,
                           input logic [4:0] rsA, input logic [4:0] rtA, input logic [4:0] rdA);
        bus.reg_dst = regDst;     bus.alu_src = aluSrc;
        bus.mem_read = memRead;   bus.mem_write = memWrite;
        bus.reg_write = regWrite; bus.mem_to_reg = memToReg;
        bus.alu_op = aluOp;
        bus.read_data_1 = rd1;    bus.read_data_2 = rd2;
        bus.ins_15_0 = imm;
        bus.rs = rsA; bus.rt = rtA; bus.rd = rdA;
    endtask

    task automatic setWb(input logic we, input logic [4:0] rdA, input logic [31:0] data);
        bus.mem_wb_reg_write = we;
        bus.mem_wb_rd        = rdA;
        bus.mem_wb_data      = data;
    endtask

    task automatic randomizeInputs();
        logic [31:0] r;
        logic [31:0] imm;
        r = $urandom();
        imm = $urandom();
        if (r[3:0] == 0) imm = {16'hFFFF, imm[15:0]};
        if (r[7:4] < 4'd12) imm[5:0] = functList[$urandom_range(0, 9)];
        setIdEx(r[8], r[9], r[10], r[11], r[12], r[13], r[16:14],
                (r[17] ? 32'($urandom_range(0, 20)) : $urandom()),
                (r[18] ? 32'($urandom_range(0, 20)) : $urandom()),
                imm,
                5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
        setWb(r[19], 5'($urandom_range(0, 3)), $urandom());
    endtask

    // One clock edge: advance the model, then sample just after the edge.
    task automatic applyStimulus();
        @(posedge clk);
        if (!reset) resetModel();
        else        stepModel();
        #1;
        compareAll();
    endtask

    initial begin
        reset = 1'b0;
        resetModel();
        randomizeInputs();
        #2;
        checkAllZero("reset.initial");
        repeat (3) begin
            applyStimulus();
            checkAllZero("reset.edge");
            randomizeInputs();
        end
        reset = 1'b1;

        setWb(0, 0, 0);
        // R-type add 5+7 into $3
        setIdEx(1, 0, 0, 0, 1, 0, 3'b010, 32'd5, 32'd7, 32'h20, 5'd1, 5'd2, 5'd3);
        applyStimulus();
        checkOutput("radd.result", bus.ex_mem_alu_result, 32'd12);
        checkOutput("radd.wreg", {27'b0, bus.ex_mem_write_reg}, 32'd3);
        checkOutput("radd.zero", {31'b0, bus.ex_mem_zero}, 32'd0);

        // add $2 = 0x10, then sub $4,$2,$2 with stale operands
        setIdEx(0, 1, 0, 0, 1, 0, 3'b000, 32'd0, 32'd0, 32'h10, 5'd0, 5'd2, 5'd0);
        applyStimulus();
        checkOutput("exfwd.producer", bus.ex_mem_alu_result, 32'h10);
        setIdEx(1, 0, 0, 0, 1, 0, 3'b010, 32'd0, 32'd0, 32'h22, 5'd2, 5'd2, 5'd4);
        applyStimulus();
        checkOutput("exfwd.result", bus.ex_mem_alu_result, 32'd0);
        checkOutput("exfwd.zero", {31'b0, bus.ex_mem_zero}, 32'd1);

        // Priority: EX/MEM $5=0xAA vs MEM/WB $5=0xBB
        setIdEx(0, 1, 0, 0, 1, 0, 3'b000, 32'd0, 32'd0, 32'hAA, 5'd0, 5'd5, 5'd0);
        applyStimulus();
        setWb(1, 5'd5, 32'hBB);
        setIdEx(0, 1, 0, 0, 0, 0, 3'b100, 32'd0, 32'd0, 32'h0, 5'd5, 5'd0, 5'd0);
        applyStimulus();
        checkOutput("prio.exmem", bus.ex_mem_alu_result, 32'hAA);
        setIdEx(0, 1, 1, 0, 1, 1, 3'b000, 32'd0, 32'd0, 32'hAA, 5'd0, 5'd5, 5'd0);
        applyStimulus();
        setIdEx(0, 1, 0, 0, 0, 0, 3'b100, 32'd0, 32'd0, 32'h0, 5'd5, 5'd0, 5'd0);
        applyStimulus();
        checkOutput("prio.loadskip", bus.ex_mem_alu_result, 32'hBB);

        // Store with address offset -4 and data forwarded from MEM/WB
        setWb(0, 0, 0);
        setIdEx(0, 0, 0, 0, 0, 0, 3'b000, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
        applyStimulus();
        setWb(1, 5'd7, 32'hDEAD);
        setIdEx(0, 1, 0, 1, 0, 0, 3'b000, 32'h100, 32'd0, 32'hFFFFFFFC, 5'd6, 5'd7, 5'd0);
        applyStimulus();
        checkOutput("store.addr", bus.ex_mem_alu_result, 32'hFC);
        checkOutput("store.data", bus.ex_mem_write_data, 32'hDEAD);
        checkOutput("store.memWrite", {31'b0, bus.ex_mem_mem_write}, 32'd1);
        setWb(0, 0, 0);

        // Edge arithmetic
        setIdEx(1, 0, 0, 0, 0, 0, 3'b101, 32'h80000000, 32'd1, 32'd0, 5'd8, 5'd9, 5'd10);
        applyStimulus();
        checkOutput("slt.overflow", bus.ex_mem_alu_result, 32'd1);
        setIdEx(1, 0, 0, 0, 1, 0, 3'b010, 32'd0, 32'h80000000, 32'h103, 5'd8, 5'd9, 5'd10);
        applyStimulus();
        checkOutput("sra.sign", bus.ex_mem_alu_result, 32'hF8000000);
        setIdEx(0, 1, 0, 0, 0, 0, 3'b100, 32'd0, 32'd0, 32'hFFFF8000, 5'd11, 5'd12, 5'd0);
        applyStimulus();
        checkOutput("ori.zext", bus.ex_mem_alu_result, 32'h00008000);

        // Writes to $0 are never forwarded from either source
        setIdEx(0, 1, 0, 0, 1, 0, 3'b000, 32'd0, 32'd0, 32'h55, 5'd12, 5'd0, 5'd0);
        applyStimulus();
        setWb(1, 5'd0, 32'h99);
        setIdEx(0, 1, 0, 0, 0, 0, 3'b000, 32'd0, 32'd0, 32'd1, 5'd0, 5'd13, 5'd0);
        applyStimulus();
        checkOutput("reg0.nofwd", bus.ex_mem_alu_result, 32'd1);

        for (int i = 0; i < 400; i++) begin
            randomizeInputs();
            applyStimulus();
        end

        // Asynchronous clear between edges, then capture on the first edge after release
        #2;
        reset = 1'b0;
        #1;
        checkAllZero("reset.async");
        resetModel();
        #1;
        reset = 1'b1;
        randomizeInputs();
        applyStimulus();

        for (int i = 0; i < 100; i++) begin
            randomizeInputs();
            applyStimulus();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule
